// File: rtl/pwm_bank_pkg.sv
// ============================================================================
//  Module      : pwm_bank_pkg
//  Description : Shared register map and widths for the PWM bank.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_bank_pkg;

    localparam int ADDR_W_DEF    = 5;
    localparam int DATA_W        = 16;

    localparam int REG_OUT_EN    = 'h00;
    localparam int REG_MODE      = 'h01;
    localparam int REG_POL       = 'h02;
    localparam int REG_PRESCALE  = 'h03;
    localparam int REG_DUTY_BASE = 'h08;

endpackage

`default_nettype wire

// File: rtl/pwm_channel.sv
// ============================================================================
//  Module      : pwm_channel
//  Description : One PWM lane: shadow/active duty, compare, polarity, output flop.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_channel
    import pwm_bank_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             wrap,
    input  logic [CNT_W-1:0] cnt,
    input  logic             duty_we,
    input  logic [CNT_W-1:0] duty_wdata,
    input  logic             out_en,
    input  logic             mode,
    input  logic             pol,
    output logic [CNT_W-1:0] active_duty,
    output logic             pwm
);

    logic [CNT_W-1:0] r_shadow;
    logic [CNT_W-1:0] r_active;
    logic             r_pwm;
    logic             w_load;
    logic             w_raw;

    // While frozen the active duty follows the shadow so a resume starts clean.
    assign w_load = wrap || !ena;

    always_comb begin
        w_raw = 1'b0;
        if (out_en) begin
            if (!mode) begin
                w_raw = 1'b1;
            end else begin
                w_raw = (cnt < r_active);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_active <= '0;
            r_pwm    <= 1'b0;
        end else begin
            if (duty_we) begin
                r_shadow <= duty_wdata;
            end
            // A write landing on the load edge bypasses the shadow.
            if (w_load) begin
                r_active <= duty_we ? duty_wdata : r_shadow;
            end
            r_pwm <= ena && (w_raw ^ (pol && out_en));
        end
    end

    assign active_duty = r_active;
    assign pwm         = r_pwm;

endmodule

`default_nettype wire

// File: rtl/pwm_bank_ctrl.sv
// ============================================================================
//  Module      : pwm_bank_ctrl
//  Description : Multi-channel PWM bank with shared prescaler/period counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_bank_ctrl
    import pwm_bank_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 8,
    parameter int PRE_W  = 16,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_err,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_p
);

    localparam logic [ADDR_W-1:0] c_a_out_en   = ADDR_W'(REG_OUT_EN);
    localparam logic [ADDR_W-1:0] c_a_mode     = ADDR_W'(REG_MODE);
    localparam logic [ADDR_W-1:0] c_a_pol      = ADDR_W'(REG_POL);
    localparam logic [ADDR_W-1:0] c_a_prescale = ADDR_W'(REG_PRESCALE);
    localparam logic [CNT_W-1:0]  c_cnt_last   = {{(CNT_W-1){1'b1}}, 1'b0};

    logic [NUM_CH-1:0] r_out_en;
    logic [NUM_CH-1:0] r_mode;
    logic [NUM_CH-1:0] r_pol;
    logic [PRE_W-1:0]  r_prescale;
    logic [PRE_W-1:0]  r_pre_cnt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_wr_err;
    logic              r_period_p;

    logic              w_fire;
    logic              w_tick;
    logic              w_wrap;
    logic              w_hit_fixed;
    logic              w_mapped;
    logic [NUM_CH-1:0] w_duty_hit;
    logic [NUM_CH-1:0] w_duty_we;
    logic [NUM_CH-1:0] w_pwm;
    logic [CNT_W-1:0]  w_active [NUM_CH];

    assign wr_ready = rst_n;
    assign w_fire   = wr_valid && wr_ready;

    always_comb begin
        w_duty_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_duty_hit[i] = (wr_addr == ADDR_W'(REG_DUTY_BASE + i));
        end
    end

    assign w_duty_we   = w_duty_hit & {NUM_CH{w_fire}};
    assign w_hit_fixed = (wr_addr == c_a_out_en) || (wr_addr == c_a_mode) ||
                         (wr_addr == c_a_pol)    || (wr_addr == c_a_prescale);
    assign w_mapped    = w_hit_fixed || (|w_duty_hit);

    // The period is MAXD ticks long, so the last count value is MAXD-1.
    assign w_tick = ena && (r_pre_cnt == r_prescale);
    assign w_wrap = w_tick && (r_cnt == c_cnt_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_en   <= '0;
            r_mode     <= '0;
            r_pol      <= '0;
            r_prescale <= '0;
            r_pre_cnt  <= '0;
            r_cnt      <= '0;
            r_wr_err   <= 1'b0;
            r_period_p <= 1'b0;
        end else begin
            r_wr_err   <= w_fire && !w_mapped;
            r_period_p <= w_wrap;

            if (w_fire && (wr_addr == c_a_out_en)) begin
                r_out_en <= wr_data[NUM_CH-1:0];
            end
            if (w_fire && (wr_addr == c_a_mode)) begin
                r_mode <= wr_data[NUM_CH-1:0];
            end
            if (w_fire && (wr_addr == c_a_pol)) begin
                r_pol <= wr_data[NUM_CH-1:0];
            end

            // Reprogramming the prescaler restarts its count immediately.
            if (w_fire && (wr_addr == c_a_prescale)) begin
                r_prescale <= wr_data[PRE_W-1:0];
                r_pre_cnt  <= '0;
            end else if (w_tick) begin
                r_pre_cnt  <= '0;
            end else if (ena) begin
                r_pre_cnt  <= r_pre_cnt + PRE_W'(1);
            end

            if (w_wrap) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .ena         (ena),
            .wrap        (w_wrap),
            .cnt         (r_cnt),
            .duty_we     (w_duty_we[g]),
            .duty_wdata  (wr_data[CNT_W-1:0]),
            .out_en      (r_out_en[g]),
            .mode        (r_mode[g]),
            .pol         (r_pol[g]),
            .active_duty (w_active[g]),
            .pwm         (w_pwm[g])
        );
    end

    always_comb begin
        rd_data = '0;
        if (rd_addr == c_a_out_en) begin
            rd_data = DATA_W'(r_out_en);
        end else if (rd_addr == c_a_mode) begin
            rd_data = DATA_W'(r_mode);
        end else if (rd_addr == c_a_pol) begin
            rd_data = DATA_W'(r_pol);
        end else if (rd_addr == c_a_prescale) begin
            rd_data = DATA_W'(r_prescale);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_addr == ADDR_W'(REG_DUTY_BASE + i)) begin
                rd_data = DATA_W'(w_active[i]);
            end
        end
    end

    assign pwm_out  = w_pwm;
    assign wr_err   = r_wr_err;
    assign period_p = r_period_p;

endmodule

`default_nettype wire

// File: tb/tb_pwm_bank_ctrl.sv
// ============================================================================
//  Module      : tb_pwm_bank_ctrl
//  Description : Self-checking bench for pwm_bank_ctrl (8 ch, 8-bit counter).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_bank_ctrl;

    localparam int NCH  = 8;
    localparam int PER  = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        wr_valid = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [4:0]  rd_addr = '0;
    logic        wr_ready;
    logic        wr_err;
    logic [15:0] rd_data;
    logic [7:0]  pwm_out;
    logic        period_p;

    always #5 clk = ~clk;

    pwm_bank_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_err   (wr_err),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .pwm_out  (pwm_out),
        .period_p (period_p)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc_n = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference state: the bank as a set of registers and a tick-driven counter.
    logic [7:0] m_oe, m_mode, m_pol, m_pwm;
    int         m_prec, m_pre, m_cnt;
    int         m_sh [NCH];
    int         m_act[NCH];
    bit         m_pp, m_err, m_valid = 1'b0;

    function automatic logic [31:0] m_rd(input int a);
        if (a == 0) return 32'(m_oe);
        if (a == 1) return 32'(m_mode);
        if (a == 2) return 32'(m_pol);
        if (a == 3) return 32'(m_prec);
        if (a >= 8 && a < 8 + NCH) return 32'(m_act[a-8]);
        return 32'd0;
    endfunction

    always @(posedge clk) begin : model
        bit         tick_v, wrap_v, err_v, load_v;
        logic [7:0] np;
        int         a;
        if (!rst_n) begin
            m_oe = '0; m_mode = '0; m_pol = '0; m_pwm = '0;
            m_prec = 0; m_pre = 0; m_cnt = 0; m_pp = 0; m_err = 0;
            for (int c = 0; c < NCH; c++) begin
                m_sh[c] = 0;
                m_act[c] = 0;
            end
            m_valid = 1'b1;
        end else begin
            np = '0;
            for (int c = 0; c < NCH; c++) begin
                if (ena && m_oe[c])
                    np[c] = m_pol[c] ^ (m_mode[c] ? (m_cnt < m_act[c]) : 1'b1);
            end
            tick_v = ena && (m_pre == m_prec);
            wrap_v = tick_v && (m_cnt == PER - 1);
            load_v = wrap_v || !ena;
            if (load_v)
                for (int c = 0; c < NCH; c++) m_act[c] = m_sh[c];
            err_v = 0;
            a = int'(wr_addr);
            if (wr_valid) begin
                if (a == 0) m_oe = wr_data[7:0];
                else if (a == 1) m_mode = wr_data[7:0];
                else if (a == 2) m_pol = wr_data[7:0];
                else if (a == 3) m_prec = int'(wr_data);
                else if (a >= 8 && a < 8 + NCH) begin
                    m_sh[a-8] = int'(wr_data[7:0]);
                    if (load_v) m_act[a-8] = int'(wr_data[7:0]);
                end else err_v = 1;
            end
            if (wr_valid && a == 3) m_pre = 0;
            else if (tick_v) m_pre = 0;
            else if (ena) m_pre = m_pre + 1;
            if (tick_v) m_cnt = (m_cnt + 1) % PER;
            m_pwm = np;
            m_pp  = wrap_v;
            m_err = err_v;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("pwm_out",  32'(pwm_out),  32'(m_pwm));
            chk("period_p", 32'(period_p), 32'(m_pp));
            chk("wr_err",   32'(wr_err),   32'(m_err));
            chk("wr_ready", 32'(wr_ready), 32'(rst_n));
            chk("rd_data",  32'(rd_data),  m_rd(int'(rd_addr)));
        end
    end

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic wait_pp(output int stamp);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!period_p && t < 4000);
        if (!period_p) chk("period_p_timeout", 32'd0, 32'd1);
        stamp = cyc_n;
    endtask

    task automatic count_hi(input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            hi += int'(pwm_out[0]);
        end
    endtask

    initial begin
        int s1, s2, hi;
        int regs[12] = '{0, 1, 2, 3, 8, 9, 10, 11, 12, 13, 14, 15};

        // Writes presented during reset must be ignored.
        wr_valid = 1'b1; wr_addr = 5'h00; wr_data = 16'hFFFF;
        repeat (3) @(posedge clk); #1;
        wr_addr = 5'h08;
        repeat (2) @(posedge clk); #1;
        wr_valid = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        foreach (regs[k]) begin
            rd_addr = 5'(regs[k]); #1;
            chk("rst_rd", 32'(rd_data), 32'd0);
        end
        rd_addr = 5'h08;

        // 50% duty, no prescale.
        wr(5'h03, 16'h0000);
        wr(5'h00, 16'h0001);
        wr(5'h01, 16'h0001);
        wr(5'h08, 16'h0080);
        wait_pp(s1);
        count_hi(PER, hi);
        chk("duty80_high", 32'(hi), 32'd128);
        wait_pp(s2);
        chk("period_gap", 32'(s2 - s1), 32'd255);
        chk("rd_duty80", 32'(rd_data), 32'h80);

        // Mid-period write stays in the shadow until the wrap.
        repeat (50) @(posedge clk); #1;
        wr(5'h08, 16'h0040);
        #1 chk("shadow_hold", 32'(rd_data), 32'h80);
        wait_pp(s1);
        count_hi(PER, hi);
        chk("duty40_high", 32'(hi), 32'd64);

        // Write landing exactly on the wrap edge takes effect in that period.
        wait_pp(s1);
        repeat (254) @(posedge clk); #1;
        wr_valid = 1'b1; wr_addr = 5'h08; wr_data = 16'h0020;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        @(negedge clk);
        chk("wrap_write_pp", 32'(period_p), 32'd1);
        chk("wrap_write_rd", 32'(rd_data), 32'h20);
        count_hi(PER, hi);
        chk("duty20_high", 32'(hi), 32'd32);

        // Duty extremes.
        wr(5'h08, 16'h00FF);
        wait_pp(s1); wait_pp(s1);
        count_hi(PER, hi);
        chk("duty_max", 32'(hi), 32'd255);
        wr(5'h08, 16'h0000);
        wait_pp(s1); wait_pp(s1);
        count_hi(PER, hi);
        chk("duty_zero", 32'(hi), 32'd0);

        // Prescale of 3 stretches each count step to four clocks.
        wr(5'h08, 16'h0080);
        wr(5'h03, 16'h0003);
        wait_pp(s1);
        count_hi(4 * PER, hi);
        chk("pre3_high", 32'(hi), 32'd512);
        wait_pp(s2);
        chk("pre3_gap", 32'(s2 - s1), 32'd1020);
        repeat (10) @(posedge clk); #1;
        wr(5'h03, 16'h0003);
        repeat (20) @(posedge clk); #1;

        // Static-high mode with polarity, then all disabled.
        wr(5'h03, 16'h0000);
        wr(5'h02, 16'h0002);
        wr(5'h01, 16'h0000);
        wr(5'h00, 16'h0003);
        repeat (2) @(negedge clk);
        chk("pol_static", 32'(pwm_out[1:0]), 32'h1);
        wr(5'h00, 16'h0000);
        repeat (2) @(negedge clk);
        chk("oe_off", 32'(pwm_out[1:0]), 32'h0);

        // Unmapped write.
        wr(5'h1F, 16'hFFFF);
        @(negedge clk);
        chk("err_pulse", 32'(wr_err), 32'd1);
        @(negedge clk);
        chk("err_clear", 32'(wr_err), 32'd0);
        rd_addr = 5'h02; #1;
        chk("err_pol_kept", 32'(rd_data), 32'h2);
        rd_addr = 5'h00; #1;
        chk("err_oe_kept", 32'(rd_data), 32'h0);
        rd_addr = 5'h08;

        // Freeze for 40 clocks mid-period: the period stretches by 40.
        wr(5'h00, 16'h0001);
        wr(5'h01, 16'h0001);
        wait_pp(s1);
        repeat (100) @(posedge clk); #1;
        ena = 1'b0;
        repeat (2) @(negedge clk);
        chk("ena_off_pwm", 32'(pwm_out), 32'd0);
        wr(5'h08, 16'h0040);
        #1 chk("ena_off_track", 32'(rd_data), 32'h40);
        repeat (37) @(posedge clk); #1;
        ena = 1'b1;
        wait_pp(s2);
        chk("freeze_gap", 32'(s2 - s1), 32'd295);
        repeat (5) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
